// File: rtl/hole_number_sequencer_if.sv
// Signal bundle between the pocket-event source / video pipeline and the hole number sequencer.
// Events are fire-and-forget pulses with no ready: pocketValid qualifies pocketHole for exactly one cycle.
interface hole_number_sequencer_if;
   logic       startOfFrame;
   logic       pocketValid;
   logic [2:0] pocketHole;
   logic       clearQueue;
   logic [2:0] holeNumber;
   logic       busy;
   logic       overflow;
   logic [1:0] fsm_state;

   modport master (
      output startOfFrame, pocketValid, pocketHole, clearQueue,
      input  holeNumber, busy, overflow, fsm_state
   );

   modport slave (
      input  startOfFrame, pocketValid, pocketHole, clearQueue,
      output holeNumber, busy, overflow, fsm_state
   );
endinterface

// File: rtl/hole_number_sequencer.sv
// Queues pocketed-hole events and announces each one as a blinking hole number,
// shown for a fixed number of frames and followed by a blank gap.
module hole_number_sequencer #(
   parameter int DISPLAY_FRAMES = 60,
   parameter int BLINK_HALF     = 8,
   parameter int GAP_FRAMES     = 10,
   parameter int FIFO_DEPTH     = 4
) (
   input logic                    clk,
   input logic                    resetN,
   hole_number_sequencer_if.slave hole_number
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SHOW = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [7:0] SHOW_LAST  = 8'(DISPLAY_FRAMES - 1);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
   localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   logic [2:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          ovf_q;

   logic [1:0] state;
   logic [7:0] frame_cnt;
   logic [7:0] blink_cnt;
   logic       phase_on;
   logic [2:0] cur_hole;
   logic [2:0] hole_q;

   logic sof;
   logic clr;
   logic valid_hole;
   logic full;
   logic empty;
   logic gap_done;
   logic pop;
   logic push;

   always_comb begin
      sof        = hole_number.startOfFrame;
      clr        = hole_number.clearQueue;
      valid_hole = hole_number.pocketValid &&
                   (hole_number.pocketHole != 3'd0) && (hole_number.pocketHole != 3'd7);
      full       = (count == FULL_CNT);
      empty      = (count == '0);
      // A zero-length gap ends on the first cycle spent in GAP, without waiting for a frame.
      gap_done   = (GAP_FRAMES == 0) || (sof && (frame_cnt == GAP_LAST));
      pop        = !clr && !empty && ((state == IDLE) || ((state == GAP) && gap_done));
      // A full queue still accepts a push when the head leaves in the same cycle.
      push       = !clr && valid_hole && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= hole_number.pocketHole;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (valid_hole && full && !pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         frame_cnt <= '0;
         blink_cnt <= '0;
         phase_on  <= 1'b0;
         cur_hole  <= '0;
         hole_q    <= '0;
      end else if (clr) begin
         state     <= IDLE;
         frame_cnt <= '0;
         blink_cnt <= '0;
         phase_on  <= 1'b0;
         cur_hole  <= '0;
         hole_q    <= '0;
      end else begin
         // Output follows the state/phase registers one cycle later.
         hole_q <= ((state == SHOW) && phase_on) ? cur_hole : 3'd0;
         case (state)
            IDLE: begin
               if (pop) begin
                  cur_hole  <= mem[rd_ptr];
                  frame_cnt <= '0;
                  blink_cnt <= '0;
                  phase_on  <= 1'b1;
                  state     <= SHOW;
               end
            end
            SHOW: begin
               if (sof) begin
                  if (frame_cnt == SHOW_LAST) begin
                     frame_cnt <= '0;
                     state     <= GAP;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
                  if (blink_cnt == BLINK_LAST) begin
                     blink_cnt <= '0;
                     phase_on  <= !phase_on;
                  end else begin
                     blink_cnt <= blink_cnt + 8'd1;
                  end
               end
            end
            GAP: begin
               if (gap_done) begin
                  frame_cnt <= '0;
                  if (pop) begin
                     cur_hole  <= mem[rd_ptr];
                     blink_cnt <= '0;
                     phase_on  <= 1'b1;
                     state     <= SHOW;
                  end else begin
                     state <= IDLE;
                  end
               end else if (sof) begin
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      hole_number.holeNumber = hole_q;
      hole_number.busy       = (state != IDLE) || !empty;
      hole_number.overflow   = ovf_q;
      hole_number.fsm_state  = state;
   end

endmodule

// File: tb/tb_hole_number_sequencer.sv
// Directed bench for hole_number_sequencer: frame-by-frame vector table plus
// hand-written sequences for overflow, full-with-pop, clear and reset.
module tb_hole_number_sequencer;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   hole_number_sequencer_if bus ();

   hole_number_sequencer #(
      .DISPLAY_FRAMES(4),
      .BLINK_HALF    (2),
      .GAP_FRAMES    (1),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk        (clk),
      .resetN     (resetN),
      .hole_number(bus)
   );

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SHOW = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       sof;
      logic       push;
      logic [2:0] hole;
      logic [2:0] exp_hole;
      logic       exp_busy;
      logic [1:0] exp_state;
   } vec_t;

   vec_t vec [22];

   logic [2:0] exp_q[$];
   logic [2:0] got_q[$];
   logic       mon_en = 1'b0;
   logic [2:0] prev_hole = 3'd0;

   // Scoreboard input: every fresh announcement (0 -> nonzero edge on holeNumber).
   always @(negedge clk) begin
      if (mon_en && (bus.holeNumber != 3'd0) && (prev_hole == 3'd0)) begin
         got_q.push_back(bus.holeNumber);
      end
      prev_hole = bus.holeNumber;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic drive_cycle(input logic sof, input logic push, input logic [2:0] hole,
                              input logic clr);
      bus.startOfFrame = sof;
      bus.pocketValid  = push;
      bus.pocketHole   = hole;
      bus.clearQueue   = clr;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      bus.pocketValid  = 1'b0;
      bus.pocketHole   = 3'd0;
      bus.clearQueue   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int n);
      for (int k = 0; k < n; k++) begin
         drive_cycle(1'b1, 1'b0, 3'd0, 1'b0);
         idle(7);
      end
   endtask

   task automatic run_table(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive_cycle(vec[i].sof, vec[i].push, vec[i].hole, 1'b0);
         idle(3);
         check($sformatf("vec[%0d].hole", i), bus.holeNumber, vec[i].exp_hole);
         check($sformatf("vec[%0d].busy", i), bus.busy, vec[i].exp_busy);
         check($sformatf("vec[%0d].state", i), bus.fsm_state, vec[i].exp_state);
      end
   endtask

   task automatic check_sb(input string name);
      check({name, ".count"}, got_q.size(), exp_q.size());
      while ((exp_q.size() > 0) && (got_q.size() > 0)) begin
         check({name, ".order"}, got_q.pop_front(), exp_q.pop_front());
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic set_vec(input int i, input logic sof, input logic push, input logic [2:0] hole,
                          input logic [2:0] eh, input logic eb, input logic [1:0] es);
      vec[i].sof       = sof;
      vec[i].push      = push;
      vec[i].hole      = hole;
      vec[i].exp_hole  = eh;
      vec[i].exp_busy  = eb;
      vec[i].exp_state = es;
   endtask

   initial begin
      // single event, hole 3: frames 3,3,0,0 then one gap frame then idle
      set_vec(0, 0, 1, 3'd3, 3'd3, 1, S_SHOW);
      set_vec(1, 1, 0, 3'd0, 3'd3, 1, S_SHOW);
      set_vec(2, 1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(3, 1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(4, 1, 0, 3'd0, 3'd0, 1, S_GAP);
      set_vec(5, 1, 0, 3'd0, 3'd0, 0, S_IDLE);
      // ordering 2,5,1 after a back-to-back push burst
      set_vec(6,  0, 0, 3'd0, 3'd2, 1, S_SHOW);
      set_vec(7,  1, 0, 3'd0, 3'd2, 1, S_SHOW);
      set_vec(8,  1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(9,  1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(10, 1, 0, 3'd0, 3'd0, 1, S_GAP);
      set_vec(11, 1, 0, 3'd0, 3'd5, 1, S_SHOW);
      set_vec(12, 1, 0, 3'd0, 3'd5, 1, S_SHOW);
      set_vec(13, 1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(14, 1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(15, 1, 0, 3'd0, 3'd0, 1, S_GAP);
      set_vec(16, 1, 0, 3'd0, 3'd1, 1, S_SHOW);
      set_vec(17, 1, 0, 3'd0, 3'd1, 1, S_SHOW);
      set_vec(18, 1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(19, 1, 0, 3'd0, 3'd0, 1, S_SHOW);
      set_vec(20, 1, 0, 3'd0, 3'd0, 1, S_GAP);
      set_vec(21, 1, 0, 3'd0, 3'd0, 0, S_IDLE);

      resetN           = 1'b0;
      bus.startOfFrame = 1'b0;
      bus.pocketValid  = 1'b0;
      bus.pocketHole   = 3'd0;
      bus.clearQueue   = 1'b0;
      idle(2);
      check("reset.hole", bus.holeNumber, 0);
      check("reset.busy", bus.busy, 0);
      check("reset.overflow", bus.overflow, 0);
      check("reset.state", bus.fsm_state, S_IDLE);
      resetN = 1'b1;
      idle(1);

      run_table(0, 5);

      drive_cycle(0, 1, 3'd2, 0);
      drive_cycle(0, 1, 3'd5, 0);
      drive_cycle(0, 1, 3'd1, 0);
      run_table(6, 21);

      // overflow with the FSM parked in SHOW (no frames)
      drive_cycle(0, 0, 3'd0, 1);
      got_q.delete();
      mon_en = 1'b1;
      exp_q  = '{3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
      drive_cycle(0, 1, 3'd4, 0);
      idle(3);
      for (int h = 1; h <= 4; h++) drive_cycle(0, 1, 3'(h), 0);
      check("ovf.before", bus.overflow, 0);
      drive_cycle(0, 1, 3'd5, 0);
      check("ovf.set", bus.overflow, 1);
      check("ovf.busy", bus.busy, 1);
      drive_cycle(0, 1, 3'd7, 0);
      check("ovf.hole7_state", bus.fsm_state, S_SHOW);
      frame(30);
      check("ovf.drain_busy", bus.busy, 0);
      check("ovf.sticky", bus.overflow, 1);
      check_sb("ovf.sb");

      // out-of-range hole indices from an empty idle queue
      drive_cycle(0, 0, 3'd0, 1);
      check("clr.ovf_cleared", bus.overflow, 0);
      drive_cycle(0, 1, 3'd7, 0);
      drive_cycle(0, 1, 3'd0, 0);
      idle(3);
      check("badhole.busy", bus.busy, 0);
      check("badhole.hole", bus.holeNumber, 0);
      check("badhole.ovf", bus.overflow, 0);

      // full queue, pop at the gap edge coincides with a push of hole 6
      exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      drive_cycle(0, 1, 3'd1, 0);
      idle(3);
      for (int h = 2; h <= 5; h++) drive_cycle(0, 1, 3'(h), 0);
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1, 0, 3'd0, 0);
         idle(3);
      end
      check("fullpop.in_gap", bus.fsm_state, S_GAP);
      drive_cycle(1, 1, 3'd6, 0);
      check("fullpop.ovf", bus.overflow, 0);
      check("fullpop.state", bus.fsm_state, S_SHOW);
      frame(30);
      check("fullpop.drain_busy", bus.busy, 0);
      check("fullpop.ovf_end", bus.overflow, 0);
      check_sb("fullpop.sb");
      mon_en = 1'b0;

      // clearQueue mid-SHOW with two events queued
      drive_cycle(0, 1, 3'd4, 0);
      idle(3);
      drive_cycle(0, 1, 3'd1, 0);
      drive_cycle(0, 1, 3'd2, 0);
      check("clr.pre_hole", bus.holeNumber, 4);
      drive_cycle(0, 0, 3'd0, 1);
      check("clr.hole", bus.holeNumber, 0);
      check("clr.busy", bus.busy, 0);
      check("clr.state", bus.fsm_state, S_IDLE);
      frame(3);
      check("clr.after_busy", bus.busy, 0);
      check("clr.after_hole", bus.holeNumber, 0);

      // asynchronous reset mid-SHOW, then an event on the first edge after release
      drive_cycle(0, 1, 3'd4, 0);
      idle(3);
      drive_cycle(0, 1, 3'd1, 0);
      drive_cycle(0, 1, 3'd2, 0);
      check("rst.pre_hole", bus.holeNumber, 4);
      #2 resetN = 1'b0;
      #1;
      check("rst.hole", bus.holeNumber, 0);
      check("rst.busy", bus.busy, 0);
      check("rst.ovf", bus.overflow, 0);
      check("rst.state", bus.fsm_state, S_IDLE);
      @(negedge clk);
      resetN = 1'b1;
      drive_cycle(0, 1, 3'd3, 0);
      idle(3);
      check("rst.first_event", bus.holeNumber, 3);
      check("rst.first_busy", bus.busy, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hole_number_sequencer.md
HOLE_NUMBER_SEQUENCER -- requirements
Module: hole_number_sequencer

Interface
REQ-001 SHALL have parameter DISPLAY_FRAMES, default 60: frames each announced hole number is shown (1..255).
REQ-002 SHALL have parameter BLINK_HALF, default 8: frames per blink on-phase and per off-phase (1..DISPLAY_FRAMES).
REQ-003 SHALL have parameter GAP_FRAMES, default 10: blank frames between consecutive announcements (0..255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: pending-event queue depth (power of two, 2..16).
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 resetN  input  1  asynchronous, active-low reset.
REQ-007 startOfFrame  input  1  one-cycle pulse per video frame.
REQ-008 pocketValid  input  1  one-cycle pulse: a ball entered a hole.
REQ-009 pocketHole  input  3  hole index 1..6 qualified by pocketValid.
REQ-010 clearQueue  input  1  synchronous flush of queue and current announcement.
REQ-011 holeNumber  output  3  hole to draw (1..6); 0 = draw nothing; drives hole_number.holeNumber.
REQ-012 busy  output  1  high in SHOW or GAP, or when queue non-empty.
REQ-013 overflow  output  1  sticky: an event was dropped due to a full queue.

Function
REQ-014 SHALL queue events FIFO-ordered: push on pocketValid with pocketHole in 1..6; pocketHole 0 or 7 SHALL be ignored without pushing or setting overflow.
REQ-015 Push when full SHALL drop the event and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-016 Push to an empty queue while in IDLE SHALL be visible to the FSM the next cycle; there is no same-cycle bypass.
REQ-017 FSM states: IDLE, SHOW, GAP.
REQ-018 IDLE: if queue non-empty, pop head into curHole, clear frameCnt and blinkCnt, go to SHOW; holeNumber = 0.
REQ-019 SHOW: each startOfFrame increments frameCnt; when frameCnt reaches DISPLAY_FRAMES-1 at a startOfFrame, go to GAP with frameCnt cleared.
REQ-020 SHOW blink: holeNumber = curHole during on-phase, 0 during off-phase; phase starts ON on SHOW entry and toggles every BLINK_HALF startOfFrame pulses.
REQ-021 GAP: holeNumber = 0; after GAP_FRAMES startOfFrame pulses, pop and go to SHOW if queue non-empty, else go to IDLE; GAP_FRAMES = 0 SHALL make the transition take effect on the cycle after leaving SHOW.
REQ-022 holeNumber SHALL be registered: it changes the cycle after the state or phase change that causes it, so it is stable for a whole frame once changed at startOfFrame.
REQ-023 Counters SHALL saturate-free wrap only through explicit clears; widths SHALL be 8 bits for frame and blink counts and $clog2(FIFO_DEPTH)+1 for occupancy.
REQ-024 clearQueue SHALL empty the queue, go to IDLE, and drive holeNumber = 0 on the next cycle; it has priority over a same-cycle push, which is discarded; overflow SHALL also clear.
REQ-025 startOfFrame coincident with pocketValid SHALL process both in the same cycle.

Reset
REQ-026 resetN low SHALL immediately force IDLE, an empty queue, zeroed counters, curHole = 0, holeNumber = 0, busy = 0, overflow = 0, including mid-SHOW.
REQ-027 After resetN deasserts, the first rising edge SHALL accept events normally.

Verification
REQ-028 Single event: DISPLAY_FRAMES=4, BLINK_HALF=2, GAP_FRAMES=1; push hole 3 -> holeNumber sequence per frame is 3,3,0,0, then 0 for 1 gap frame, then IDLE with busy=0.
REQ-029 Ordering: push 2, 5, 1 back-to-back -> announced in order 2, 5, 1, each separated by GAP_FRAMES blank frames.
REQ-030 Overflow: FIFO_DEPTH=4, FSM stalled in SHOW, push 5 events -> 4 queued, 5th dropped, overflow=1; push hole 7 -> ignored with no queue change.
REQ-031 Full with pop: queue full, in GAP at the pop edge, same-cycle push of hole 6 -> accepted, overflow stays 0, hole 6 announced last.
REQ-032 Reset/clear mid-SHOW: holeNumber=4 with 2 queued; clearQueue -> holeNumber=0 next cycle, busy=0; repeat with resetN low -> holeNumber=0 asynchronously.
